sram_rd_streamer: RTL and testbench

- Read-side sequencer for the 32-bit x 2048-word single-port SRAM macro.
- On a start command it issues `len` consecutive reads from `base_addr` and hands each word to the downstream consumer (array input FIFO) over a valid/ready stream.
- It absorbs the macro's 1-cycle read latency and downstream backpressure with a 2-entry buffer. No word is lost and none is duplicated.

---
 rtl/sram_pkg.sv | 14 +
 rtl/stream_fifo2.sv | 60 ++++++
 rtl/sram_rd_streamer.sv | 129 ++++++++++++
 tb/tb_sram_rd_streamer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared constants and FSM state type for the SRAM read-side streamer.
package sram_pkg;

    localparam int SRAM_ADDR_W = 11;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_DEPTH  = 1 << SRAM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry data buffer between the SRAM read port and the output stream.
// Push and pop may coincide at any occupancy, including when full.
module stream_fifo2 #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [1:0]        o_occ
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_occ;
    logic              w_push;
    logic              w_pop;

    // A pop on an empty buffer is meaningless; a push into a full buffer is
    // only accepted when the head leaves in the same cycle.
    assign w_pop  = i_pop && (r_occ != 2'd0);
    assign w_push = i_push && ((r_occ != 2'd2) || w_pop);

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_occ != 2'd0);
    assign o_occ   = r_occ;

    // Storage, pointers and occupancy update on push/pop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the two data slots are reset as well, so the stream data
            // output reads 0 after reset instead of X; a real RAM array would not be.
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments let the full-buffer case write
            // the slot being popped this same edge without an ordering hazard.
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/sram_rd_streamer.sv
// Read-side sequencer: issues len consecutive SRAM reads from base_addr and
// streams the words out over valid/ready, hiding the 1-cycle read latency
// and downstream backpressure behind a 2-entry buffer.
module sram_rd_streamer
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int LEN_W  = 12
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              sram_CEN,
    output logic              sram_WEN,
    output logic [ADDR_W-1:0] sram_A,
    input  logic [DATA_W-1:0] sram_Q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_acc_cnt;
    logic              r_inflight;

    logic [1:0]        w_occ;
    logic [2:0]        w_pending;
    logic              w_pop;
    logic              w_issue;
    logic              w_last_pop;

    // Words that will sit in the buffer after this edge if no new read is
    // issued: current occupancy plus the word on sram_Q minus the one leaving.
    assign w_pop      = out_valid && out_ready;
    assign w_pending  = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue    = (r_state == RUN) && (r_remaining != '0) && (w_pending < 3'd2);
    assign w_last_pop = w_pop && (LEN_W'(r_acc_cnt + 1'b1) == r_len);

    assign sram_CEN = ~w_issue;
    assign sram_WEN = 1'b1;
    assign sram_A   = w_issue ? r_rd_addr : '0;

    stream_fifo2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_push  (r_inflight),
        .i_data  (sram_Q),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_valid (out_valid),
        .o_occ   (w_occ)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through the case leaves it unassigned (no latch).
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last_pop) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Command capture, read address/remaining count, delivered-word count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_len       <= '0;
            r_acc_cnt   <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if ((r_state == IDLE) && start) begin
                r_rd_addr   <= base_addr;
                r_remaining <= len;
                r_len       <= len;
                r_acc_cnt   <= '0;
            end else begin
                if (w_issue) begin
                    r_rd_addr   <= r_rd_addr + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                end
                if (w_pop) begin
                    r_acc_cnt <= r_acc_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Self-checking bench for sram_rd_streamer: directed table, hand-written
// corner sequences (stall, reset abort, ignored start) and randomized
// transfers against a queue-based reference of the expected word stream.
module tb_sram_rd_streamer;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 12;
    localparam int DEPTH  = 2048;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy, done;
    logic              sram_CEN, sram_WEN;
    logic [ADDR_W-1:0] sram_A;
    logic [DATA_W-1:0] sram_Q = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;

    sram_rd_streamer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .sram_CEN  (sram_CEN),
        .sram_WEN  (sram_WEN),
        .sram_A    (sram_A),
        .sram_Q    (sram_Q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 CLK = ~CLK;

    // SRAM macro model: 1-cycle read latency, Q holds until the next read.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge CLK) begin
        if (sram_CEN == 1'b0) sram_Q <= mem[sram_A];
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Observations from the most recent transfer.
    logic [31:0] data_q[$];
    int          addr_q[$];
    int          issue_cyc_q[$];
    int done_cycle, done_cnt, first_valid, busy_at_done, busy_after;
    int wen_bad, a_bad, stab_bad, hold_bad, timed_out;

    // Runs one transfer with start in cycle 0. mode: 0 ready always high,
    // 1 ready low in cycles s0..s1, 2 random ready. A second start
    // (base xs_base) is pulsed in cycle xs_cyc while busy.
    task automatic run_xfer(input int b, input int l, input int mode,
                            input int s0, input int s1, input int xs_cyc, input int xs_base);
        int          budget;
        bit          seen_done;
        bit          prev_stall;
        logic [31:0] prev_data;
        budget = 4 * l + 60;
        data_q.delete(); addr_q.delete(); issue_cyc_q.delete();
        done_cycle = -1; done_cnt = 0; first_valid = -1; busy_at_done = -1; busy_after = -1;
        wen_bad = 0; a_bad = 0; stab_bad = 0; hold_bad = 0; timed_out = 1;
        seen_done = 0; prev_stall = 0; prev_data = '0;
        @(negedge CLK);
        start = 1'b1; base_addr = b[ADDR_W-1:0]; len = l[LEN_W-1:0]; out_ready = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge CLK);
            start = 1'b0;
            if (cyc == xs_cyc) begin
                start = 1'b1; base_addr = xs_base[ADDR_W-1:0]; len = 12'd3;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !(cyc >= s0 && cyc <= s1);
                default: out_ready = ($urandom_range(0, 99) < 70);
            endcase
            #1;
            if (seen_done) begin
                busy_after = int'(busy | done);
                timed_out  = 0;
                break;
            end
            if (sram_WEN !== 1'b1) wen_bad++;
            if (sram_CEN === 1'b1 && sram_A !== '0) a_bad++;
            if (sram_CEN === 1'b0) begin
                addr_q.push_back(int'(sram_A));
                issue_cyc_q.push_back(cyc);
            end
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stab_bad++;
            if (mode == 1 && cyc >= s0 && cyc <= s1 &&
                (out_valid !== 1'b1 || out_data !== mem[b & (DEPTH - 1)])) hold_bad++;
            if (out_valid === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                if (out_ready) data_q.push_back(out_data);
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_data  = out_data;
            if (done === 1'b1) begin
                done_cnt++;
                done_cycle   = cyc;
                busy_at_done = int'(busy);
                seen_done    = 1;
            end
        end
        start = 1'b0;
    endtask

    // Reference: a transfer delivers mem[(b+i) mod depth], i = 0..l-1, exactly once.
    task automatic check_common(input string tag, input int b, input int l);
        int bad_d, bad_a;
        bad_d = 0; bad_a = 0;
        check($sformatf("%s_timeout", tag), timed_out, 0);
        check($sformatf("%s_done_cnt", tag), done_cnt, 1);
        check($sformatf("%s_busy_at_done", tag), busy_at_done, 1);
        check($sformatf("%s_busy_after", tag), busy_after, 0);
        check($sformatf("%s_n_words", tag), data_q.size(), l);
        for (int i = 0; i < data_q.size() && i < l; i++)
            if (data_q[i] !== mem[(b + i) & (DEPTH - 1)]) bad_d++;
        check($sformatf("%s_bad_words", tag), bad_d, 0);
        check($sformatf("%s_n_reads", tag), addr_q.size(), l);
        for (int i = 0; i < addr_q.size() && i < l; i++)
            if (addr_q[i] != ((b + i) & (DEPTH - 1))) bad_a++;
        check($sformatf("%s_bad_addrs", tag), bad_a, 0);
        check($sformatf("%s_wen_low", tag), wen_bad, 0);
        check($sformatf("%s_a_nonzero_idle", tag), a_bad, 0);
        check($sformatf("%s_unstable", tag), stab_bad, 0);
    endtask

    typedef struct {
        int base;
        int len;
        int exp_done;
        int exp_first;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   n_pre, n_done, n_valid;
        int   rb, rl;

        tbl[0] = '{base: 32'h010, len: 4,  exp_done: 7,  exp_first: 3};
        tbl[1] = '{base: 32'h7FE, len: 4,  exp_done: 7,  exp_first: 3};
        tbl[2] = '{base: 32'h000, len: 0,  exp_done: 1,  exp_first: -1};
        tbl[3] = '{base: 32'h123, len: 1,  exp_done: 4,  exp_first: 3};
        tbl[4] = '{base: 32'h7FF, len: 2,  exp_done: 5,  exp_first: 3};
        tbl[5] = '{base: 32'h3F0, len: 16, exp_done: 19, exp_first: 3};

        for (int a = 0; a < DEPTH; a++) mem[a] = a;

        // Reset values.
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_cen", sram_CEN, 1);
        check("rst_wen", sram_WEN, 1);
        check("rst_addr", sram_A, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // Directed table, ready always high.
        for (int v = 0; v < 6; v++) begin
            run_xfer(tbl[v].base, tbl[v].len, 0, 0, 0, -1, 0);
            check_common($sformatf("tbl%0d", v), tbl[v].base, tbl[v].len);
            check($sformatf("tbl%0d_done_cycle", v), done_cycle, tbl[v].exp_done);
            check($sformatf("tbl%0d_first_valid", v), first_valid, tbl[v].exp_first);
        end

        // Backpressure: ready low in cycles 3..8.
        run_xfer(32'h010, 4, 1, 3, 8, -1, 0);
        check_common("stall", 32'h010, 4);
        n_pre = 0;
        foreach (issue_cyc_q[i]) if (issue_cyc_q[i] < 9) n_pre++;
        check("stall_reads_before_resume", n_pre, 2);
        check("stall_hold_0x10", hold_bad, 0);
        check("stall_first_valid", first_valid, 3);
        check("stall_done_cycle", done_cycle, 13);

        // Reset asserted in cycle 4 of a len=8 transfer.
        @(negedge CLK);
        start = 1'b1; base_addr = 11'h040; len = 12'd8; out_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            start = 1'b0;
        end
        @(negedge CLK);
        #1;
        check("abort_pre_valid", out_valid, 1);
        check("abort_pre_cen", sram_CEN, 0);
        RST_N = 1'b0;
        #1;
        check("abort_cen", sram_CEN, 1);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_addr", sram_A, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        n_done = 0; n_valid = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            #1;
            if (done === 1'b1) n_done++;
            if (out_valid === 1'b1 || sram_CEN !== 1'b1) n_valid++;
        end
        check("abort_no_done", n_done, 0);
        check("abort_quiet", n_valid, 0);
        run_xfer(32'h100, 2, 0, 0, 0, -1, 0);
        check_common("post_abort", 32'h100, 2);
        check("post_abort_done_cycle", done_cycle, 5);

        // Start pulsed while busy must be ignored.
        run_xfer(32'h020, 6, 0, 0, 0, 3, 32'h200);
        check_common("ignore_start", 32'h020, 6);
        check("ignore_start_done_cycle", done_cycle, 9);

        // Randomized transfers against the reference stream.
        for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
        for (int t = 0; t < 25; t++) begin
            rb = int'($urandom_range(0, DEPTH - 1));
            rl = (t % 8 == 7) ? int'($urandom_range(100, 200)) : int'($urandom_range(0, 40));
            run_xfer(rb, rl, 2, 0, 0, -1, 0);
            check_common($sformatf("rnd%0d", t), rb, rl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
